// File: rtl/screen_pkg.sv
// Shared screen encoding and default game constants for the screen sequencer
// and the color_mapper select decode.
package screen_pkg;

  typedef enum logic [1:0] {
    HOME    = 2'b00,
    FIGHT   = 2'b01,
    P1_WINS = 2'b10,
    P2_WINS = 2'b11
  } screen_t;

  localparam int STOCKS_DEF          = 3;
  localparam int KO_GRACE_FRAMES_DEF = 120;
  localparam int GO_HOLD_FRAMES_DEF  = 300;

  // Width of a counter that must hold every value 0..max_val
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Game-flow signal bundle between keyboard/hit-detection logic and the
// screen sequencer. master drives the inputs, slave is the sequencer.
interface screen_sequencer_if;
  logic       frame_tick;
  logic       start_key;
  logic       pause_key;
  logic       ko1;
  logic       ko2;
  logic [1:0] current_screen;
  logic [1:0] c1_stocks;
  logic [1:0] c2_stocks;
  logic       respawn1;
  logic       respawn2;
  logic       paused;

  modport master (
    output frame_tick, start_key, pause_key, ko1, ko2,
    input  current_screen, c1_stocks, c2_stocks, respawn1, respawn2, paused
  );

  modport slave (
    input  frame_tick, start_key, pause_key, ko1, ko2,
    output current_screen, c1_stocks, c2_stocks, respawn1, respawn2, paused
  );
endinterface

// File: rtl/screen_sequencer_key_edge.sv
// key_edge: turns a held key level into a single-cycle pulse on its rising edge.
module key_edge (
  input  logic Clk,
  input  logic Reset,
  input  logic level,
  output logic rise
);

  logic level_d_r;

  // Remember last cycle's key level
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      level_d_r <= 1'b0;
    end else begin
      level_d_r <= level;
    end
  end

  assign rise = level & ~level_d_r;

endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: HOME -> FIGHT -> P1_WINS/P2_WINS -> HOME game flow with
// stock counts, per-player KO grace timers and frame-aligned screen commits.
// Optional feature macro: SCREEN_PAUSE_EN (pause toggle during FIGHT).
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int STOCKS          = STOCKS_DEF,
  parameter int KO_GRACE_FRAMES = KO_GRACE_FRAMES_DEF,
  parameter int GO_HOLD_FRAMES  = GO_HOLD_FRAMES_DEF
) (
  input logic               Clk,
  input logic               Reset,
  screen_sequencer_if.slave bus
);

  localparam int GW = cnt_width(KO_GRACE_FRAMES);
  localparam int HW = cnt_width(GO_HOLD_FRAMES);
  localparam logic [1:0]    STOCK_INIT = 2'(STOCKS);
  localparam logic [GW-1:0] GRACE_INIT = GW'(KO_GRACE_FRAMES);
  localparam logic [GW-1:0] GRACE_ONE  = {{(GW-1){1'b0}}, 1'b1};
  localparam logic [GW-1:0] GRACE_ZERO = {GW{1'b0}};
  localparam logic [HW-1:0] HOLD_LAST  = HW'(GO_HOLD_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_ONE   = {{(HW-1){1'b0}}, 1'b1};
  localparam logic [HW-1:0] HOLD_ZERO  = {HW{1'b0}};

  screen_t       state_r, state_nxt_s;
  logic [1:0]    screen_r;
  logic [1:0]    stocks1_r, stocks2_r, stocks1_nxt_s, stocks2_nxt_s;
  logic [1:0]    dec1_s, dec2_s;
  logic [GW-1:0] grace1_r, grace2_r, grace1_nxt_s, grace2_nxt_s;
  logic [GW-1:0] grace1_tick_s, grace2_tick_s;
  logic [HW-1:0] hold_r, hold_nxt_s;
  logic          respawn1_r, respawn2_r;
  logic          start_evt_s, freeze_s, fight_live_s;
  logic          acc1_s, acc2_s;

  key_edge u_start_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .level (bus.start_key),
    .rise  (start_evt_s)
  );

  // KO acceptance, post-KO stock values and frame-driven grace countdown
  always_comb begin
    fight_live_s = (state_r == FIGHT) && !freeze_s;
    acc1_s = fight_live_s && bus.ko1 && (grace1_r == GRACE_ZERO) && (stocks1_r != 2'd0);
    acc2_s = fight_live_s && bus.ko2 && (grace2_r == GRACE_ZERO) && (stocks2_r != 2'd0);
    if (acc1_s) dec1_s = stocks1_r - 2'd1; else dec1_s = stocks1_r;
    if (acc2_s) dec2_s = stocks2_r - 2'd1; else dec2_s = stocks2_r;
    if (bus.frame_tick && !freeze_s && (grace1_r != GRACE_ZERO)) grace1_tick_s = grace1_r - GRACE_ONE;
    else grace1_tick_s = grace1_r;
    if (bus.frame_tick && !freeze_s && (grace2_r != GRACE_ZERO)) grace2_tick_s = grace2_r - GRACE_ONE;
    else grace2_tick_s = grace2_r;
  end

  // FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_r <= HOME;
    else       state_r <= state_nxt_s;
  end

  // FSM next-state: start edge, stock exhaustion and game-over hold timeout
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      HOME: begin
        if (start_evt_s) state_nxt_s = FIGHT;
        else             state_nxt_s = HOME;
      end
      FIGHT: begin
        if ((dec1_s == 2'd0) && (dec2_s == 2'd0)) state_nxt_s = FIGHT;
        else if (dec1_s == 2'd0)                  state_nxt_s = P2_WINS;
        else if (dec2_s == 2'd0)                  state_nxt_s = P1_WINS;
        else                                      state_nxt_s = FIGHT;
      end
      P1_WINS, P2_WINS: begin
        if (start_evt_s || (bus.frame_tick && (hold_r == HOLD_LAST))) state_nxt_s = HOME;
        else                                                          state_nxt_s = state_r;
      end
      default: state_nxt_s = HOME;
    endcase
  end

  // FSM outputs: stock, grace and hold counter updates per state
  always_comb begin
    stocks1_nxt_s = stocks1_r;
    stocks2_nxt_s = stocks2_r;
    grace1_nxt_s  = grace1_tick_s;
    grace2_nxt_s  = grace2_tick_s;
    hold_nxt_s    = hold_r;
    case (state_r)
      HOME: begin
        if (start_evt_s) begin
          stocks1_nxt_s = STOCK_INIT;
          stocks2_nxt_s = STOCK_INIT;
          grace1_nxt_s  = GRACE_ZERO;
          grace2_nxt_s  = GRACE_ZERO;
        end else begin
          stocks1_nxt_s = stocks1_r;
          stocks2_nxt_s = stocks2_r;
        end
      end
      FIGHT: begin
        // hold stays cleared for the whole fight so game-over starts from 0
        hold_nxt_s = HOLD_ZERO;
        if ((dec1_s == 2'd0) && (dec2_s == 2'd0)) begin
          // sudden death: both players back to one stock, both protected
          stocks1_nxt_s = 2'd1;
          stocks2_nxt_s = 2'd1;
          grace1_nxt_s  = GRACE_INIT;
          grace2_nxt_s  = GRACE_INIT;
        end else begin
          stocks1_nxt_s = dec1_s;
          stocks2_nxt_s = dec2_s;
          if (acc1_s) grace1_nxt_s = GRACE_INIT; else grace1_nxt_s = grace1_tick_s;
          if (acc2_s) grace2_nxt_s = GRACE_INIT; else grace2_nxt_s = grace2_tick_s;
        end
      end
      P1_WINS, P2_WINS: begin
        if (bus.frame_tick) hold_nxt_s = hold_r + HOLD_ONE;
        else                hold_nxt_s = hold_r;
      end
      default: hold_nxt_s = HOLD_ZERO;
    endcase
  end

  // Datapath registers; the visible screen follows the state only on frame ticks
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      screen_r   <= 2'b00;
      stocks1_r  <= 2'd0;
      stocks2_r  <= 2'd0;
      grace1_r   <= GRACE_ZERO;
      grace2_r   <= GRACE_ZERO;
      hold_r     <= HOLD_ZERO;
      respawn1_r <= 1'b0;
      respawn2_r <= 1'b0;
    end else begin
      if (bus.frame_tick) screen_r <= state_r;
      stocks1_r  <= stocks1_nxt_s;
      stocks2_r  <= stocks2_nxt_s;
      grace1_r   <= grace1_nxt_s;
      grace2_r   <= grace2_nxt_s;
      hold_r     <= hold_nxt_s;
      respawn1_r <= acc1_s;
      respawn2_r <= acc2_s;
    end
  end

`ifdef SCREEN_PAUSE_EN
  logic pause_evt_s, paused_r, paused_nxt_s;

  key_edge u_pause_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .level (bus.pause_key),
    .rise  (pause_evt_s)
  );

  // Pause toggles only inside FIGHT and is dropped whenever FIGHT is left
  always_comb begin
    if (state_nxt_s != FIGHT)                 paused_nxt_s = 1'b0;
    else if ((state_r == FIGHT) && pause_evt_s) paused_nxt_s = ~paused_r;
    else                                      paused_nxt_s = paused_r;
  end

  // Pause flag register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) paused_r <= 1'b0;
    else       paused_r <= paused_nxt_s;
  end

  assign freeze_s   = paused_r;
  assign bus.paused = paused_r;
`else
  logic unused_pause_s;
  assign unused_pause_s = bus.pause_key;
  assign freeze_s       = 1'b0;
  assign bus.paused     = 1'b0;
`endif

  assign bus.current_screen = screen_r;
  assign bus.c1_stocks      = stocks1_r;
  assign bus.c2_stocks      = stocks2_r;
  assign bus.respawn1       = respawn1_r;
  assign bus.respawn2       = respawn2_r;

endmodule

// File: tb/tb_screen_sequencer.sv
// Randomized bench for screen_sequencer against a rule-level game model.
module tb_screen_sequencer;
  import screen_pkg::*;

  localparam int P_STOCKS = 3;
  localparam int P_GRACE  = 120;
  localparam int P_HOLD   = 300;
  localparam int M_HOME = 0, M_FIGHT = 1, M_P1 = 2, M_P2 = 3;

  logic Clk = 1'b0;
  logic Reset;
  screen_sequencer_if sif ();

  screen_sequencer #(
    .STOCKS          (P_STOCKS),
    .KO_GRACE_FRAMES (P_GRACE),
    .GO_HOLD_FRAMES  (P_HOLD)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (sif)
  );

  always #5 Clk = ~Clk;

  int n_cmp;
  int n_bad;

  // model of the game as the player sees it
  int m_state, m_screen, m_s1, m_s2, m_g1, m_g2, m_hold;
  int m_rsp1, m_rsp2, m_paused;
  bit m_start_prev, m_pause_prev;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_HOME; m_screen = 0; m_s1 = 0; m_s2 = 0; m_g1 = 0; m_g2 = 0;
    m_hold = 0; m_rsp1 = 0; m_rsp2 = 0; m_paused = 0;
    m_start_prev = 1'b0; m_pause_prev = 1'b0;
  endtask

  task automatic model_step(input bit tick, input bit start, input bit pause,
                            input bit k1, input bit k2);
    int ns;
    bit sev, pev, a1, a2;
    sev = start && !m_start_prev;
`ifdef SCREEN_PAUSE_EN
    pev = pause && !m_pause_prev;
`else
    pev = 1'b0;
`endif
    ns = m_state;
    m_rsp1 = 0;
    m_rsp2 = 0;
    // the screen shows whatever the game state was when the frame began
    if (tick) m_screen = m_state;
    case (m_state)
      M_HOME: begin
        if (sev) begin
          ns = M_FIGHT; m_s1 = P_STOCKS; m_s2 = P_STOCKS; m_g1 = 0; m_g2 = 0;
        end
      end
      M_FIGHT: begin
        if (m_paused == 0) begin
          a1 = k1 && (m_g1 == 0);
          a2 = k2 && (m_g2 == 0);
          if (tick && m_g1 > 0) m_g1 = m_g1 - 1;
          if (tick && m_g2 > 0) m_g2 = m_g2 - 1;
          if (a1) begin m_s1 = m_s1 - 1; m_g1 = P_GRACE; end
          if (a2) begin m_s2 = m_s2 - 1; m_g2 = P_GRACE; end
          m_rsp1 = a1;
          m_rsp2 = a2;
          if (m_s1 == 0 && m_s2 == 0) begin
            m_s1 = 1; m_s2 = 1; m_g1 = P_GRACE; m_g2 = P_GRACE;
          end else if (m_s1 == 0) begin
            ns = M_P2;
          end else if (m_s2 == 0) begin
            ns = M_P1;
          end
        end
        if (pev) m_paused = (m_paused == 0) ? 1 : 0;
        if (ns != M_FIGHT) begin m_hold = 0; m_paused = 0; end
      end
      default: begin
        if (sev) ns = M_HOME;
        else if (tick) begin
          if (m_hold == P_HOLD - 1) ns = M_HOME;
          else m_hold = m_hold + 1;
        end
      end
    endcase
    m_state = ns;
    m_start_prev = start;
    m_pause_prev = pause;
  endtask

  task automatic check_outputs();
    check_val("screen",   sif.current_screen, m_screen);
    check_val("stocks1",  sif.c1_stocks,      m_s1);
    check_val("stocks2",  sif.c2_stocks,      m_s2);
    check_val("respawn1", sif.respawn1,       m_rsp1);
    check_val("respawn2", sif.respawn2,       m_rsp2);
    check_val("paused",   sif.paused,         m_paused);
  endtask

  // called just after a falling edge: drive, predict, then check one cycle later
  task automatic run_cycle(input bit tick, input bit start, input bit pause,
                           input bit k1, input bit k2);
    sif.frame_tick = tick;
    sif.start_key  = start;
    sif.pause_key  = pause;
    sif.ko1        = k1;
    sif.ko2        = k2;
    model_step(tick, start, pause, k1, k2);
    @(negedge Clk);
    check_outputs();
  endtask

  task automatic apply_reset();
    sif.frame_tick = 1'b0; sif.start_key = 1'b0; sif.pause_key = 1'b0;
    sif.ko1 = 1'b0; sif.ko2 = 1'b0;
    Reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(negedge Clk);
    @(negedge Clk);
    check_outputs();
    Reset = 1'b0;
  endtask

  int  frame_left;
  bit  tick, start_lvl, pause_lvl, k1, k2;
  int  sd_budget;

  function automatic bit next_tick();
    if (frame_left == 0) begin
      frame_left = $urandom_range(4, 2);
      return 1'b1;
    end
    frame_left = frame_left - 1;
    return 1'b0;
  endfunction

  initial begin
    n_cmp = 0; n_bad = 0;
    frame_left = 3; start_lvl = 1'b0; pause_lvl = 1'b0; sd_budget = 4;
    Reset = 1'b1;
    @(negedge Clk);
    apply_reset();

    // start key held for about ten frames: one FIGHT entry only
    for (int c = 0; c < 40; c++) run_cycle(next_tick(), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) run_cycle(next_tick(), 1'b0, 1'b0, 1'b0, 1'b0);

    for (int c = 0; c < 30000; c++) begin
      if (c == 15000) apply_reset();
      tick = next_tick();
      if ($urandom_range(399, 0) == 0) start_lvl = ~start_lvl;
      if ($urandom_range(299, 0) == 0) pause_lvl = ~pause_lvl;
      k1 = ($urandom_range(59, 0) == 0);
      k2 = ($urandom_range(59, 0) == 0);
      if (m_state == M_FIGHT && m_s1 == 1 && m_s2 == 1 && m_g1 == 0 && m_g2 == 0 &&
          m_paused == 0 && sd_budget > 0 && $urandom_range(3, 0) == 0) begin
        k1 = 1'b1; k2 = 1'b1; sd_budget = sd_budget - 1;
      end
      run_cycle(tick, start_lvl, pause_lvl, k1, k2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
